// File: rtl/sched_pkg.sv
// Shared types and the fixed schedule table for the schedule executor.
package sched_pkg;
  localparam int SCHED_ID_W = 2;
  localparam int MIN_ID     = 1;
  localparam int MAX_ID     = 3;

  localparam logic [15:0] ID1_BASE = 16'h0000;
  localparam logic [15:0] ID1_LEN  = 16'd4;
  localparam logic        ID1_WE   = 1'b0;
  localparam logic [15:0] ID2_BASE = 16'h0100;
  localparam logic [15:0] ID2_LEN  = 16'd8;
  localparam logic        ID2_WE   = 1'b1;
  localparam logic [15:0] ID3_BASE = 16'h0200;
  localparam logic [15:0] ID3_LEN  = 16'd1;
  localparam logic        ID3_WE   = 1'b0;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DONE} state_e;

  typedef struct packed {
    logic [15:0] base;
    logic [15:0] len;
    logic        we;
  } sched_ent_t;

  function automatic sched_ent_t sched_lookup(input logic [SCHED_ID_W-1:0] id);
    sched_ent_t e;
    e = '{base: 16'h0, len: 16'd1, we: 1'b0};
    case (id)
      2'd1:    e = '{base: ID1_BASE, len: ID1_LEN, we: ID1_WE};
      2'd2:    e = '{base: ID2_BASE, len: ID2_LEN, we: ID2_WE};
      2'd3:    e = '{base: ID3_BASE, len: ID3_LEN, we: ID3_WE};
      default: e = '{base: 16'h0, len: 16'd1, we: 1'b0};
    endcase
    return e;
  endfunction
endpackage

// File: rtl/schedule_executor_if.sv
// Single-beat memory request bus driven by the schedule executor.
interface schedule_executor_if #(parameter int ADDR_W = 16) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ack);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ack);
endinterface

// File: rtl/sched_fifo.sv
// Small synchronous FIFO of schedule IDs; head is visible combinationally, no empty bypass.
module sched_fifo
  import sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [SCHED_ID_W-1:0] i_din,
  input  logic                  i_pop,
  output logic [SCHED_ID_W-1:0] o_dout,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [CW-1:0]         o_count
);
  logic [SCHED_ID_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr, r_rd;
  logic [CW-1:0]         r_count;
  logic                  w_push, w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_din;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/schedule_executor.sv
// Queues schedule IDs from the selector and runs each as a burst of single-beat memory requests.
module schedule_executor
  import sched_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx,
  input  logic [31:0]           scheduleIn,
  schedule_executor_if.master   mem,
  output logic                  busy,
  output logic                  done,
  output logic [SCHED_ID_W-1:0] done_id,
  output logic                  err_id,
  output logic                  err_ovf,
  output logic                  err_timeout
);
  localparam int TMO_W = $clog2(TIMEOUT) + 1;
  localparam int CW    = $clog2(DEPTH) + 1;

  state_e                r_state, w_state_nxt;
  logic [SCHED_ID_W-1:0] r_id, r_done_id, w_head;
  logic [ADDR_W-1:0]     r_addr;
  logic [15:0]           r_beat, r_len;
  logic                  r_we;
  logic [TMO_W-1:0]      r_tmo;
  logic                  r_err_id, r_err_ovf, r_err_tmo;
  logic                  w_legal, w_full, w_empty;
  logic [CW-1:0]         w_count;
  logic                  w_pop, w_load, w_beat_inc, w_tmo_inc, w_finish, w_abort;
  sched_ent_t            w_ent;

  // scheduleIn may be X while tx is low, so tx gates the range check.
  assign w_legal = tx && (scheduleIn >= 32'(MIN_ID)) && (scheduleIn <= 32'(MAX_ID));
  assign w_ent   = sched_lookup(w_head);

  sched_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_legal),
    .i_din   (scheduleIn[SCHED_ID_W-1:0]),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_beat_inc  = 1'b0;
    w_tmo_inc   = 1'b0;
    w_finish    = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_load      = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mem.mem_ack) begin
          if (r_beat == r_len - 16'd1) begin
            w_finish    = 1'b1;
            w_state_nxt = ST_DONE;
          end else begin
            w_beat_inc = 1'b1;
          end
        end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_tmo_inc = 1'b1;
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_id      <= '0;
      r_done_id <= '0;
      r_addr    <= '0;
      r_beat    <= '0;
      r_len     <= '0;
      r_we      <= 1'b0;
      r_tmo     <= '0;
      r_err_id  <= 1'b0;
      r_err_ovf <= 1'b0;
      r_err_tmo <= 1'b0;
    end else begin
      r_err_id  <= tx && !w_legal;
      r_err_ovf <= w_legal && w_full;
      r_err_tmo <= w_abort;
      if (w_load) begin
        r_id   <= w_head;
        r_addr <= ADDR_W'(w_ent.base);
        r_len  <= w_ent.len;
        r_we   <= w_ent.we;
        r_beat <= '0;
        r_tmo  <= '0;
      end
      if (w_beat_inc) begin
        r_beat <= r_beat + 16'd1;
        r_addr <= r_addr + ADDR_W'(1);
        r_tmo  <= '0;
      end
      if (w_tmo_inc) r_tmo <= r_tmo + TMO_W'(1);
      if (w_finish || w_abort) r_done_id <= r_id;
    end
  end

  assign mem.mem_req   = (r_state == ST_ISSUE);
  assign mem.mem_we    = r_we;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_wdata = {14'd0, r_id, r_beat};
  assign busy          = (r_state != ST_IDLE) || (w_count != '0);
  assign done          = (r_state == ST_DONE);
  assign done_id       = r_done_id;
  assign err_id        = r_err_id;
  assign err_ovf       = r_err_ovf;
  assign err_timeout   = r_err_tmo;
endmodule

// File: tb/tb_schedule_executor.sv
// Directed bench for schedule_executor: bursts, backpressure, overflow, timeout, reset, streaming.
module tb_schedule_executor;
  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rst, tx;
  logic [31:0] scheduleIn;
  logic        busy, done, err_id, err_ovf, err_timeout;
  logic [1:0]  done_id;

  int n_tot = 0, n_bad = 0;
  int n_done = 0, n_eid = 0, n_eovf = 0, n_etmo = 0;
  logic [1:0] done_log[$];

  schedule_executor_if #(.ADDR_W(16)) bus ();

  schedule_executor #(.DEPTH(4), .ADDR_W(16), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx          (tx),
    .scheduleIn  (scheduleIn),
    .mem         (bus.master),
    .busy        (busy),
    .done        (done),
    .done_id     (done_id),
    .err_id      (err_id),
    .err_ovf     (err_ovf),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin n_done++; done_log.push_back(done_id); end
      if (err_id) n_eid++;
      if (err_ovf) n_eovf++;
      if (err_timeout) n_etmo++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [31:0] id);
    tx = 1'b1; scheduleIn = id;
    tick();
    tx = 1'b0; scheduleIn = 32'hxxxx_xxxx;
  endtask

  // Entered on the first ISSUE cycle; acks every 'period'-th cycle.
  task automatic run_burst(input int id, input int base, input int len, input int we, input int period);
    int beat = 0, cyc = 0, d0;
    logic a;
    d0 = n_done;
    while (beat < len && cyc < 200) begin
      chk("req", 32'(bus.mem_req), 1);
      chk("addr", 32'(bus.mem_addr), 32'(base + beat));
      chk("we", 32'(bus.mem_we), 32'(we));
      chk("wdata", bus.mem_wdata, {16'(id), 16'(beat)});
      a = ((cyc % period) == period - 1);
      bus.mem_ack = a;
      tick();
      if (a) beat++;
      cyc++;
    end
    chk("burst_beats", 32'(beat), 32'(len));
    bus.mem_ack = 1'b0;
    chk("done_hi", 32'(done), 1);
    chk("done_id", 32'(done_id), 32'(id));
    chk("req_lo", 32'(bus.mem_req), 0);
    tick();
    chk("done_lo", 32'(done), 0);
    chk("one_done", 32'(n_done - d0), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n, d0, e0, o0, t0, i0;
    rst = 1'b1; tx = 1'b0; scheduleIn = '0; bus.mem_ack = 1'b0;
    tick(); tick();
    chk("rst_req", 32'(bus.mem_req), 0);
    chk("rst_addr", 32'(bus.mem_addr), 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flags", {27'd0, done, err_id, err_ovf, err_timeout, bus.mem_we}, 0);
    chk("rst_did", 32'(done_id), 0);
    rst = 1'b0;
    tick();

    // 1: ID1, ack always high
    push(1);
    chk("t1_nobypass", 32'(bus.mem_req), 0);
    chk("t1_busy", 32'(busy), 1);
    tick();
    run_burst(1, 'h0000, 4, 0, 1);
    chk("t1_idle", 32'(busy), 0);

    // 2: ID2, ack every 3rd cycle
    push(2);
    tick();
    run_burst(2, 'h0100, 8, 1, 3);
    chk("t2_idle", 32'(busy), 0);

    // 3: fill the queue with ack low, then overflow and illegal IDs
    o0 = n_eovf;
    push(1);
    push(2); chk("t3_pop", 32'(bus.mem_req), 1);
    chk("t3_first", bus.mem_wdata, 32'h0001_0000);
    push(3);
    push(1);
    push(2);
    chk("t3_cnt4", 32'(dut.u_fifo.o_count), 4);
    chk("t3_no_ovf", 32'(n_eovf - o0), 0);
    push(3);
    chk("t3_ovf", 32'(err_ovf), 1);
    chk("t3_ovf_eid", 32'(err_id), 0);
    push(0);
    chk("t3_eid0", 32'(err_id), 1);
    chk("t3_eid0_ovf", 32'(err_ovf), 0);
    push(7);
    chk("t3_eid7", 32'(err_id), 1);
    tick();
    chk("t3_cnt_keep", 32'(dut.u_fifo.o_count), 4);
    chk("t3_pulse_end", 32'(err_id), 0);
    rst = 1'b1; tick(); rst = 1'b0; tick();

    // 4: ID3 timeout, then queued ID1 runs
    d0 = n_done;
    push(3);
    push(1);
    n = 0;
    while (bus.mem_req && n < 200) begin
      chk("t4_no_tmo_early", 32'(err_timeout), 0);
      n++;
      tick();
    end
    chk("t4_req_cycles", 32'(n), 32'(TMO));
    chk("t4_tmo", 32'(err_timeout), 1);
    chk("t4_did", 32'(done_id), 3);
    chk("t4_nodone", 32'(n_done - d0), 0);
    tick();
    chk("t4_tmo_lo", 32'(err_timeout), 0);
    run_burst(1, 'h0000, 4, 0, 1);

    // 5: reset mid-burst with two IDs queued
    push(2);
    tx = 1'b1; scheduleIn = 3; tick();
    scheduleIn = 1; bus.mem_ack = 1'b1; tick();
    tx = 1'b0; tick();
    chk("t5_mid", 32'(bus.mem_addr), 32'h0102);
    chk("t5_q2", 32'(dut.u_fifo.o_count), 2);
    d0 = n_done; e0 = n_eid; o0 = n_eovf; t0 = n_etmo;
    rst = 1'b1; bus.mem_ack = 1'b0; tick(); rst = 1'b0;
    chk("t5_req", 32'(bus.mem_req), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_q0", 32'(dut.u_fifo.o_count), 0);
    chk("t5_addr", 32'(bus.mem_addr), 0);
    tick();
    chk("t5_no_pulse", 32'((n_done - d0) + (n_eid - e0) + (n_eovf - o0) + (n_etmo - t0)), 0);
    push(3);
    tick();
    run_burst(3, 'h0200, 1, 0, 1);

    // 6: selector-style stream, tx every 2nd cycle
    done_log.delete();
    i0 = 0; d0 = n_done; o0 = n_eovf; n = 0;
    bus.mem_ack = 1'b1;
    while ((n_done - d0) < 4 && n < 300) begin
      if (n % 2 == 0 && i0 < 4) begin
        tx = 1'b1;
        scheduleIn = (i0 == 3) ? 32'd1 : 32'(i0 + 1);
        i0++;
      end else begin
        tx = 1'b0;
      end
      tick();
      n++;
    end
    tx = 1'b0; bus.mem_ack = 1'b0;
    tick();
    chk("t6_ndone", 32'(done_log.size()), 4);
    if (done_log.size() == 4) begin
      chk("t6_d0", 32'(done_log[0]), 1);
      chk("t6_d1", 32'(done_log[1]), 2);
      chk("t6_d2", 32'(done_log[2]), 3);
      chk("t6_d3", 32'(done_log[3]), 1);
    end
    chk("t6_no_ovf", 32'(n_eovf - o0), 0);
    chk("t6_idle", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
